// File: rtl/fib_codec_pkg.sv
// Shared constants, state type and Fibonacci helper functions for the
// Zeckendorf codec family.
package fib_codec_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   // F(0)=0, F(1)=F(2)=1
   function automatic longint unsigned fib(input int n);
      longint unsigned a = 0;
      longint unsigned b = 1;
      longint unsigned t;
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int fib_min(input int bin_w);
      longint unsigned lim = (64'd1 << bin_w) - 64'd1;
      int w = 1;
      while (fib(w + 2) <= lim) w++;
      return w;
   endfunction

   function automatic int calc_wgt_w(input int fib_w);
      return $clog2(fib(fib_w + 1) + 64'd1);
   endfunction

endpackage

// File: rtl/fib_codec_weight_gen.sv
// Fibonacci weight generator: walks (F(k+2), F(k+1)) downwards one step per
// cycle so the current digit weight never needs a lookup table.
module fib_weight_gen
   import fib_codec_pkg::*;
#(
   parameter int FIB_W = 32,
   parameter int WGT_W = calc_wgt_w(FIB_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   output logic [WGT_W-1:0] weight
);

   localparam logic [WGT_W-1:0] A_INIT = WGT_W'(fib(FIB_W + 1));
   localparam logic [WGT_W-1:0] B_INIT = WGT_W'(fib(FIB_W));

   logic [WGT_W-1:0] a_q;
   logic [WGT_W-1:0] b_q;

   // (a,b) -> (b, a-b) reverses the Fibonacci recurrence
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q <= '0;
         b_q <= '0;
      end else if (load) begin
         a_q <= A_INIT;
         b_q <= B_INIT;
      end else if (step) begin
         a_q <= b_q;
         b_q <= a_q - b_q;
      end
   end

   assign weight = a_q;

endmodule

// File: rtl/fib_codec_p.sv
// Bit-serial Zeckendorf codec: greedy encode of a binary value or weighted-sum
// decode of a Fibonacci code, one digit per cycle, most significant first.
module fib_codec_p
   import fib_codec_pkg::*;
#(
   parameter int BIN_W = 16,
   parameter int FIB_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [BIN_W-1:0] in_bin,
   input  logic [FIB_W-1:0] in_fib,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_mode,
   output logic [FIB_W-1:0] out_fib,
   output logic [BIN_W-1:0] out_bin,
   output logic             overflow,
   output logic             noncanon
);

   localparam int WGT_W = calc_wgt_w(FIB_W);
   localparam int DW    = ((BIN_W > WGT_W) ? BIN_W : WGT_W) + 1;
   localparam int KW    = $clog2(FIB_W);
   localparam logic [DW-1:0] BIN_MAX = {{(DW-BIN_W){1'b0}}, {BIN_W{1'b1}}};
   localparam logic [KW-1:0] K_TOP   = KW'(FIB_W - 1);

   if (BIN_W < 4 || BIN_W > 32 || FIB_W < fib_min(BIN_W) || FIB_W > 48) begin : g_bad_params
      $error("fib_codec_p: BIN_W/FIB_W combination out of range");
   end

   state_t           state_q, state_d;
   logic             accept, run;
   logic [WGT_W-1:0] weight;
   logic [DW-1:0]    wgt_ext, acc_sum;
   logic [DW-1:0]    rem_q, acc_q;
   logic [KW-1:0]    k_q;
   logic [FIB_W-1:0] fib_in_q, fib_out_q;
   logic             mode_q, ovf_q, nc_q, prev_q, digit;

   fib_weight_gen #(.FIB_W(FIB_W), .WGT_W(WGT_W)) u_wgen (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .step   (run),
      .weight (weight)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      run       = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            run = 1'b1;
            if (k_q == '0) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wgt_ext = {{(DW-WGT_W){1'b0}}, weight};
   assign acc_sum = acc_q + wgt_ext;
   assign digit   = fib_in_q[k_q];

   // prev_q carries digit k+1 so adjacency is caught without indexing past the top
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q    <= MODE_ENC;
         rem_q     <= '0;
         acc_q     <= '0;
         k_q       <= '0;
         fib_in_q  <= '0;
         fib_out_q <= '0;
         ovf_q     <= 1'b0;
         nc_q      <= 1'b0;
         prev_q    <= 1'b0;
      end else if (accept) begin
         mode_q    <= in_mode;
         rem_q     <= {{(DW-BIN_W){1'b0}}, in_bin};
         acc_q     <= '0;
         k_q       <= K_TOP;
         fib_in_q  <= in_fib;
         fib_out_q <= '0;
         ovf_q     <= 1'b0;
         nc_q      <= 1'b0;
         prev_q    <= 1'b0;
      end else if (run) begin
         k_q <= k_q - 1'b1;
         if (mode_q == MODE_ENC) begin
            if (rem_q >= wgt_ext) begin
               fib_out_q[k_q] <= 1'b1;
               rem_q          <= rem_q - wgt_ext;
            end
         end else begin
            prev_q <= digit;
            if (digit && prev_q) nc_q <= 1'b1;
            if (digit) begin
               if (acc_sum > BIN_MAX) begin
                  ovf_q <= 1'b1;
                  acc_q <= BIN_MAX;
               end else begin
                  acc_q <= acc_sum;
               end
            end
         end
      end
   end

   assign out_mode = mode_q;
   assign out_fib  = fib_out_q;
   assign out_bin  = acc_q[BIN_W-1:0];
   assign overflow = ovf_q;
   assign noncanon = nc_q;

endmodule

// File: tb/tb_fib_codec_p.sv
// Self-checking bench for fib_codec_p: fixed vectors, random traffic against
// a Zeckendorf reference model, backpressure and reset-abort sequences.
module tb_fib_codec_p;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, in_ready, in_mode = 1'b0;
   logic [15:0] in_bin = '0;
   logic [31:0] in_fib = '0;
   logic        out_valid, out_ready = 1'b0, out_mode, overflow, noncanon;
   logic [31:0] out_fib;
   logic [15:0] out_bin;

   logic        s_in_valid = 1'b0, s_in_ready, s_in_mode = 1'b0;
   logic [7:0]  s_in_bin = '0;
   logic [11:0] s_in_fib = '0;
   logic        s_out_valid, s_out_ready = 1'b0, s_out_mode, s_overflow, s_noncanon;
   logic [11:0] s_out_fib;
   logic [7:0]  s_out_bin;

   int errors = 0;
   int checks = 0;
   bit hung = 1'b0;

   logic [31:0] r_fib;
   logic [15:0] r_bin;
   logic        r_ovf, r_nc, r_mode, r_ready;
   int          r_lat;

   fib_codec_p #(.BIN_W(16), .FIB_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_bin(in_bin), .in_fib(in_fib),
      .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
      .out_fib(out_fib), .out_bin(out_bin), .overflow(overflow), .noncanon(noncanon)
   );

   fib_codec_p #(.BIN_W(8), .FIB_W(12)) dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_mode(s_in_mode), .in_bin(s_in_bin), .in_fib(s_in_fib),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_mode(s_out_mode),
      .out_fib(s_out_fib), .out_bin(s_out_bin), .overflow(s_overflow), .noncanon(s_noncanon)
   );

   always #5 clk = ~clk;

   // Reference model: Zeckendorf arithmetic with digit i weighing F(i+2)
   function automatic longint unsigned fibn(input int n);
      longint unsigned a = 0, b = 1, t;
      for (int i = 0; i < n; i++) begin
         t = a + b; a = b; b = t;
      end
      return a;
   endfunction

   function automatic logic [47:0] ref_enc(input longint unsigned v, input int fw);
      logic [47:0] c = '0;
      longint unsigned r = v;
      for (int i = fw - 1; i >= 0; i--)
         if (fibn(i + 2) <= r) begin
            c[i] = 1'b1;
            r -= fibn(i + 2);
         end
      return c;
   endfunction

   function automatic longint unsigned ref_sum(input logic [47:0] c, input int fw);
      longint unsigned s = 0;
      for (int i = 0; i < fw; i++) if (c[i]) s += fibn(i + 2);
      return s;
   endfunction

   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic note_timeout(input string name);
      checks++;
      errors++;
      hung = 1'b1;
      $display("[TB] FAIL %s: no response within cycle budget", name);
   endtask

   task automatic send_req(input logic mode, input logic [15:0] b, input logic [31:0] f);
      int n = 0;
      in_mode = mode; in_bin = b; in_fib = f; in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         in_valid = 1'b0;
         note_timeout("accept");
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      r_lat = 0;
      while (!out_valid && r_lat < 200) begin
         @(posedge clk); #1; r_lat++;
      end
      if (!out_valid) begin
         note_timeout("out_valid");
         return;
      end
      r_fib = out_fib; r_bin = out_bin; r_ovf = overflow; r_nc = noncanon;
      r_mode = out_mode; r_ready = in_ready;
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic apply_stimulus(input logic mode, input logic [15:0] b, input logic [31:0] f, input logic early);
      if (hung) return;
      send_req(mode, b, f);
      if (hung) return;
      if (early) out_ready = 1'b1;
      wait_out();
      if (hung) return;
      take_out();
   endtask

   // Compare captured result against the reference model
   task automatic check_model(input logic mode, input logic [15:0] b, input logic [31:0] f);
      longint unsigned s;
      if (hung) return;
      check_output("latency", 64'(r_lat), 64'd32);
      check_output("mode", 64'(r_mode), 64'(mode));
      if (mode == 1'b0) begin
         check_output("enc_fib", 64'(r_fib), 64'(ref_enc(64'(b), 32)));
         check_output("enc_canon", 64'(r_fib & (r_fib >> 1)), 64'd0);
         check_output("enc_roundtrip", ref_sum(48'(r_fib), 32), 64'(b));
         check_output("enc_bin", 64'(r_bin), 64'd0);
         check_output("enc_flags", {62'd0, r_ovf, r_nc}, 64'd0);
      end else begin
         s = ref_sum(48'(f), 32);
         check_output("dec_ovf", 64'(r_ovf), (s > 64'd65535) ? 64'd1 : 64'd0);
         check_output("dec_bin", 64'(r_bin), (s > 64'd65535) ? 64'hFFFF : s);
         check_output("dec_nc", 64'(r_nc), ((f & (f >> 1)) != 0) ? 64'd1 : 64'd0);
         check_output("dec_fib", 64'(r_fib), 64'd0);
      end
   endtask

   task automatic small_txn(input logic mode, input logic [7:0] b, input logic [11:0] f);
      int n = 0;
      s_in_mode = mode; s_in_bin = b; s_in_fib = f; s_in_valid = 1'b1;
      while (!s_in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      n = 0;
      while (!s_out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      if (!s_out_valid) begin
         note_timeout("small_out_valid");
         return;
      end
      check_output("small_latency", 64'(n), 64'd12);
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
   endtask

   typedef struct {
      logic        mode;
      logic [15:0] bin;
      logic [31:0] fib;
      logic [31:0] exp_fib;
      logic [15:0] exp_bin;
      logic        exp_ovf;
      logic        exp_nc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b0, 16'd100,   32'h0,        32'h00000214, 16'd0,      1'b0, 1'b0};
      vecs[1] = '{1'b0, 16'd65535, 32'h0,        32'h00505204, 16'd0,      1'b0, 1'b0};
      vecs[2] = '{1'b0, 16'd0,     32'h0,        32'h00000000, 16'd0,      1'b0, 1'b0};
      vecs[3] = '{1'b1, 16'd0,     32'h00000214, 32'h0,        16'd100,    1'b0, 1'b0};
      vecs[4] = '{1'b1, 16'd0,     32'h00000003, 32'h0,        16'd3,      1'b0, 1'b1};
      vecs[5] = '{1'b1, 16'd0,     32'hFFFFFFFF, 32'h0,        16'hFFFF,   1'b1, 1'b1};

      #1;
      check_output("rst_in_ready", 64'(in_ready), 64'd1);
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      check_output("rst_outputs", {out_fib, out_bin, 13'd0, out_mode, overflow, noncanon}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].mode, vecs[i].bin, vecs[i].fib, 1'b0);
         if (!hung) begin
            check_output($sformatf("vec%0d_fib", i), 64'(r_fib), 64'(vecs[i].exp_fib));
            check_output($sformatf("vec%0d_bin", i), 64'(r_bin), 64'(vecs[i].exp_bin));
            check_output($sformatf("vec%0d_ovf", i), 64'(r_ovf), 64'(vecs[i].exp_ovf));
            check_output($sformatf("vec%0d_nc", i), 64'(r_nc), 64'(vecs[i].exp_nc));
            check_output($sformatf("vec%0d_lat", i), 64'(r_lat), 64'd32);
            check_output($sformatf("vec%0d_busy", i), 64'(r_ready), 64'd0);
         end
      end

      // Random encodes, raw decodes and decodes of canonical codes
      for (int i = 0; i < 150 && !hung; i++) begin
         logic        m;
         logic [15:0] b;
         logic [31:0] f;
         m = 1'(i % 3 != 0);
         b = 16'($urandom);
         if (i % 3 == 2)      f = 32'(ref_enc(64'($urandom_range(0, 65535)), 32));
         else if (i % 6 == 1) f = 32'($urandom) & 32'h007FFFFF;
         else                 f = 32'($urandom);
         apply_stimulus(m, b, f, 1'(i % 2));
         check_model(m, b, f);
      end

      // Backpressure with a pending request queued behind the result
      if (!hung) begin
         send_req(1'b0, 16'd100, 32'h0);
         wait_out();
         if (!hung) begin
            in_mode = 1'b1; in_fib = 32'h00000214; in_bin = 16'd0; in_valid = 1'b1;
            for (int c = 0; c < 5; c++) begin
               @(posedge clk); #1;
               check_output("bp_fib", 64'(out_fib), 64'h214);
               check_output("bp_valid", 64'(out_valid), 64'd1);
               check_output("bp_in_ready", 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check_output("bp_idle_ready", 64'(in_ready), 64'd1);
            check_output("bp_idle_valid", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check_output("bp_accepted", 64'(in_ready), 64'd0);
            wait_out();
            if (!hung) begin
               check_output("bp_next_bin", 64'(r_bin), 64'd100);
               check_output("bp_next_mode", 64'(r_mode), 64'd1);
               check_output("bp_next_lat", 64'(r_lat), 64'd32);
               take_out();
            end
         end
      end

      // Reset in the middle of a decode aborts it cleanly
      if (!hung) begin
         send_req(1'b1, 16'd0, 32'hFFFFFFFF);
         repeat (9) begin
            @(posedge clk); #1;
         end
         rst = 1'b0;
         #1;
         check_output("abort_outputs", {out_fib, out_bin, 13'd0, out_mode, overflow, noncanon}, 64'd0);
         check_output("abort_valid", 64'(out_valid), 64'd0);
         @(posedge clk); #1;
         rst = 1'b1;
         check_output("abort_in_ready", 64'(in_ready), 64'd1);
         apply_stimulus(1'b0, 16'd65535, 32'h0, 1'b0);
         if (!hung) check_output("abort_next_fib", 64'(r_fib), 64'h00505204);
      end

      // Narrow instance: encode sweep and an overflowing decode
      if (!hung) begin
         small_txn(1'b0, 8'd255, 12'h0);
         if (!hung) check_output("small_enc255", 64'(s_out_fib), 64'h841);
         for (int v = 0; v < 256 && !hung; v++) begin
            small_txn(1'b0, 8'(v), 12'h0);
            if (!hung) begin
               check_output("small_enc", 64'(s_out_fib), 64'(ref_enc(64'(v), 12)));
               check_output("small_enc_bin", 64'(s_out_bin), 64'd0);
            end
         end
         if (!hung) begin
            small_txn(1'b1, 8'd0, 12'hFFF);
            if (!hung) begin
               check_output("small_dec_bin", 64'(s_out_bin), 64'hFF);
               check_output("small_dec_flags", {62'd0, s_overflow, s_noncanon}, 64'd3);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
